// File: rtl/serial_io_bridge.sv
// Byte bridge between the processor serial port and the host byte link.
// Two first-word fall-through FIFOs (host->proc RX, proc->host TX) plus sticky error flags.

module serial_io_bridge_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            push_data_i,
    input  logic                  push_req_i,
    input  logic                  pop_req_i,
    output logic [7:0]            head_o,
    output logic                  not_empty_o,
    output logic                  not_full_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push, pop;

    assign not_empty_o = (count_q != CW'(0));
    assign not_full_o  = (count_q != CW'(DEPTH));
    assign count_o     = count_q;
    assign head_o      = not_empty_o ? mem_q[rd_ptr_q] : 8'h00;

    // Pop is gated on the pre-edge occupancy, so push+pop on empty only pushes.
    assign push = push_req_i && not_full_o;
    assign pop  = pop_req_i  && not_empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

module serial_io_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            host_rx_data,
    input  logic                  host_rx_valid,
    output logic                  host_rx_ready,
    output logic [7:0]            host_tx_data,
    output logic                  host_tx_valid,
    input  logic                  host_tx_ready,
    output logic [7:0]            proc_serial_in,
    output logic                  proc_serial_valid_in,
    output logic                  proc_serial_ready_in,
    input  logic [7:0]            proc_serial_out,
    input  logic                  proc_serial_rden_out,
    input  logic                  proc_serial_wren_out,
    input  logic                  clear_flags,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic                  rx_underflow,
    output logic                  tx_overflow
);
    logic rx_not_empty, rx_not_full;
    logic tx_not_empty, tx_not_full;
    logic rx_underflow_q, rx_underflow_d;
    logic tx_overflow_q,  tx_overflow_d;

    serial_io_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_data_i (host_rx_data),
        .push_req_i  (host_rx_valid),
        .pop_req_i   (proc_serial_rden_out),
        .head_o      (proc_serial_in),
        .not_empty_o (rx_not_empty),
        .not_full_o  (rx_not_full),
        .count_o     (rx_count)
    );

    serial_io_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_data_i (proc_serial_out),
        .push_req_i  (proc_serial_wren_out),
        .pop_req_i   (host_tx_ready),
        .head_o      (host_tx_data),
        .not_empty_o (tx_not_empty),
        .not_full_o  (tx_not_full),
        .count_o     (tx_count)
    );

    assign host_rx_ready        = rx_not_full;
    assign proc_serial_valid_in = rx_not_empty;
    assign proc_serial_ready_in = tx_not_full;
    assign host_tx_valid        = tx_not_empty;

    // Sticky flags: a new error in the same cycle as a clear keeps the flag set.
    always_comb begin
        rx_underflow_d = (rx_underflow_q && !clear_flags) ||
                         (proc_serial_rden_out && !rx_not_empty);
        tx_overflow_d  = (tx_overflow_q && !clear_flags) ||
                         (proc_serial_wren_out && !tx_not_full);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_underflow_q <= 1'b0;
            tx_overflow_q  <= 1'b0;
        end else begin
            rx_underflow_q <= rx_underflow_d;
            tx_overflow_q  <= tx_overflow_d;
        end
    end

    assign rx_underflow = rx_underflow_q;
    assign tx_overflow  = tx_overflow_q;
endmodule

// File: tb/tb_serial_io_bridge.sv
// Directed + random bench for serial_io_bridge against a queue-based reference model.
module tb_serial_io_bridge;
    localparam int unsigned DL2 = 4;
    localparam int DEPTH = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   host_rx_data = 8'h00;
    logic         host_rx_valid = 1'b0;
    logic         host_rx_ready;
    logic [7:0]   host_tx_data;
    logic         host_tx_valid;
    logic         host_tx_ready = 1'b0;
    logic [7:0]   proc_serial_in;
    logic         proc_serial_valid_in;
    logic         proc_serial_ready_in;
    logic [7:0]   proc_serial_out = 8'h00;
    logic         proc_serial_rden_out = 1'b0;
    logic         proc_serial_wren_out = 1'b0;
    logic         clear_flags = 1'b0;
    logic [DL2:0] rx_count;
    logic [DL2:0] tx_count;
    logic         rx_underflow;
    logic         tx_overflow;

    serial_io_bridge #(.DEPTH_LOG2(DL2)) dut (
        .clock                (clock),
        .reset                (reset),
        .host_rx_data         (host_rx_data),
        .host_rx_valid        (host_rx_valid),
        .host_rx_ready        (host_rx_ready),
        .host_tx_data         (host_tx_data),
        .host_tx_valid        (host_tx_valid),
        .host_tx_ready        (host_tx_ready),
        .proc_serial_in       (proc_serial_in),
        .proc_serial_valid_in (proc_serial_valid_in),
        .proc_serial_ready_in (proc_serial_ready_in),
        .proc_serial_out      (proc_serial_out),
        .proc_serial_rden_out (proc_serial_rden_out),
        .proc_serial_wren_out (proc_serial_wren_out),
        .clear_flags          (clear_flags),
        .rx_count             (rx_count),
        .tx_count             (tx_count),
        .rx_underflow         (rx_underflow),
        .tx_overflow          (tx_overflow)
    );

    always #5 clock = ~clock;

    // Reference model: byte queues and two sticky bits.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_ufl = 1'b0;
    bit         m_ofl = 1'b0;
    bit         last_rx_accepted = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rx_count",      32'(rx_count),             32'(rxq.size()));
        chk("tx_count",      32'(tx_count),             32'(txq.size()));
        chk("host_rx_ready", 32'(host_rx_ready),        32'(rxq.size() < DEPTH));
        chk("proc_valid_in", 32'(proc_serial_valid_in), 32'(rxq.size() > 0));
        chk("proc_ready_in", 32'(proc_serial_ready_in), 32'(txq.size() < DEPTH));
        chk("host_tx_valid", 32'(host_tx_valid),        32'(txq.size() > 0));
        chk("proc_serial_in", 32'(proc_serial_in),      32'(rxq.size() > 0 ? rxq[0] : 8'h00));
        chk("host_tx_data",  32'(host_tx_data),         32'(txq.size() > 0 ? txq[0] : 8'h00));
        chk("rx_underflow",  32'(rx_underflow),         32'(m_ufl));
        chk("tx_overflow",   32'(tx_overflow),          32'(m_ofl));
    endtask

    // One clock: update the model from the inputs sampled at the edge, then compare.
    task automatic cycle();
        int  rxn;
        int  txn;
        bit  rpush, rpop, tpush, tpop;
        logic [7:0] dropped;
        @(posedge clock);
        rxn   = rxq.size();
        txn   = txq.size();
        rpush = host_rx_valid && (rxn < DEPTH);
        rpop  = proc_serial_rden_out && (rxn > 0);
        tpush = proc_serial_wren_out && (txn < DEPTH);
        tpop  = host_tx_ready && (txn > 0);
        m_ufl = (m_ufl && !clear_flags) || (proc_serial_rden_out && rxn == 0);
        m_ofl = (m_ofl && !clear_flags) || (proc_serial_wren_out && txn == DEPTH);
        if (rpop) dropped = rxq.pop_front();
        if (rpush) rxq.push_back(host_rx_data);
        if (tpop) dropped = txq.pop_front();
        if (tpush) txq.push_back(proc_serial_out);
        last_rx_accepted = rpush;
        #1;
        check_all();
    endtask

    task automatic push_rx(input logic [7:0] b);
        host_rx_valid = 1'b1;
        host_rx_data  = b;
        cycle();
        host_rx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        proc_serial_wren_out = 1'b1;
        proc_serial_out      = b;
        cycle();
        proc_serial_wren_out = 1'b0;
    endtask

    initial begin
        logic [7:0] exp3 [3];
        exp3 = '{8'h11, 8'h22, 8'h33};

        // Reset
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
        cycle();

        // Single byte through RX, then one pop
        push_rx(8'hA5);
        chk("a5_valid", 32'(proc_serial_valid_in), 32'd1);
        chk("a5_data",  32'(proc_serial_in),       32'hA5);
        proc_serial_rden_out = 1'b1;
        cycle();
        proc_serial_rden_out = 1'b0;
        chk("a5_popped_valid", 32'(proc_serial_valid_in), 32'd0);
        chk("a5_popped_count", 32'(rx_count),             32'd0);

        // Fill RX, hold the 17th byte, drain in order, then wrap
        for (int i = 0; i < 16; i++) push_rx(8'(i));
        chk("rx_full_count", 32'(rx_count),      32'd16);
        chk("rx_full_ready", 32'(host_rx_ready), 32'd0);
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h10;
        repeat (2) cycle();
        chk("rx_held_count", 32'(rx_count), 32'd16);
        host_rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("rx_order", 32'(proc_serial_in), 32'(i));
            proc_serial_rden_out = 1'b1;
            cycle();
        end
        proc_serial_rden_out = 1'b0;
        chk("rx_drained", 32'(rx_count), 32'd0);
        push_rx(8'h55);
        chk("rx_wrap_data", 32'(proc_serial_in), 32'h55);
        proc_serial_rden_out = 1'b1;
        cycle();
        proc_serial_rden_out = 1'b0;

        // TX with host stalled, then released
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        repeat (2) cycle();
        chk("tx_stall_count", 32'(tx_count),      32'd3);
        chk("tx_stall_valid", 32'(host_tx_valid), 32'd1);
        chk("tx_stall_data",  32'(host_tx_data),  32'h11);
        host_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("tx_stream_data", 32'(host_tx_data), 32'(exp3[i]));
            cycle();
        end
        host_tx_ready = 1'b0;
        chk("tx_stream_done", 32'(host_tx_valid), 32'd0);

        // TX overflow and flag behaviour
        for (int i = 0; i < 16; i++) push_tx(8'($urandom_range(0, 255)));
        push_tx(8'h99);
        chk("ovf_count", 32'(tx_count),    32'd16);
        chk("ovf_flag",  32'(tx_overflow), 32'd1);
        repeat (2) cycle();
        chk("ovf_sticky", 32'(tx_overflow), 32'd1);
        clear_flags = 1'b1;
        cycle();
        clear_flags = 1'b0;
        chk("ovf_cleared", 32'(tx_overflow), 32'd0);
        proc_serial_rden_out = 1'b1;
        cycle();
        proc_serial_rden_out = 1'b0;
        chk("ufl_flag", 32'(rx_underflow), 32'd1);
        proc_serial_rden_out = 1'b1;
        clear_flags = 1'b1;
        cycle();
        proc_serial_rden_out = 1'b0;
        chk("ufl_set_wins", 32'(rx_underflow), 32'd1);
        cycle();
        clear_flags = 1'b0;
        chk("ufl_cleared", 32'(rx_underflow), 32'd0);
        host_tx_ready = 1'b1;
        repeat (17) cycle();
        host_tx_ready = 1'b0;

        // Simultaneous push/pop at occupancy 5
        for (int i = 0; i < 5; i++) push_rx(8'($urandom_range(0, 255)));
        host_rx_valid = 1'b1;
        proc_serial_rden_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host_rx_data = 8'($urandom_range(0, 255));
            cycle();
            chk("simul_count", 32'(rx_count), 32'd5);
        end
        host_rx_valid = 1'b0;
        repeat (5) cycle();
        chk("simul_drained", 32'(rx_count), 32'd0);
        host_rx_valid = 1'b1;
        host_rx_data  = 8'h3C;
        cycle();
        host_rx_valid = 1'b0;
        proc_serial_rden_out = 1'b0;
        chk("empty_pp_count", 32'(rx_count),     32'd1);
        chk("empty_pp_ufl",   32'(rx_underflow), 32'd1);
        chk("empty_pp_data",  32'(proc_serial_in), 32'h3C);
        clear_flags = 1'b1;
        cycle();
        clear_flags = 1'b0;

        // Random traffic: fill-biased phase then drain-biased phase
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 250; i++) begin
                if (!host_rx_valid || last_rx_accepted) begin
                    host_rx_valid = ($urandom_range(0, 3) != 0) ^ (ph == 1 && $urandom_range(0, 1) == 0);
                    host_rx_data  = 8'($urandom_range(0, 255));
                end
                proc_serial_rden_out = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
                proc_serial_wren_out = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
                proc_serial_out      = 8'($urandom_range(0, 255));
                host_tx_ready        = (ph == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
                clear_flags          = ($urandom_range(0, 15) == 0);
                cycle();
            end
        end
        host_rx_valid = 1'b0;
        proc_serial_rden_out = 1'b0;
        proc_serial_wren_out = 1'b0;
        host_tx_ready = 1'b0;
        clear_flags = 1'b0;
        cycle();

        // Asynchronous reset mid-cycle with both FIFOs partially full
        for (int i = 0; i < 4; i++) begin
            host_rx_valid = 1'b1;
            host_rx_data  = 8'($urandom_range(0, 255));
            proc_serial_wren_out = 1'b1;
            proc_serial_out = 8'($urandom_range(0, 255));
            cycle();
        end
        host_rx_valid = 1'b0;
        proc_serial_wren_out = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        rxq.delete();
        txq.delete();
        m_ufl = 1'b0;
        m_ofl = 1'b0;
        check_all();
        chk("arst_rx_count", 32'(rx_count),             32'd0);
        chk("arst_tx_count", 32'(tx_count),             32'd0);
        chk("arst_rx_ready", 32'(host_rx_ready),        32'd1);
        chk("arst_tx_valid", 32'(host_tx_valid),        32'd0);
        chk("arst_pvalid",   32'(proc_serial_valid_in), 32'd0);
        chk("arst_pready",   32'(proc_serial_ready_in), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
